// File: rtl/pio_isr.sv
// rtl/pio_isr.sv - PIO input shift register with autopush and RX FIFO push path
//
// Purpose: receive-direction shift register of a PIO state machine. Executes
// IN, PUSH and MOV-to-ISR operations from the instruction decoder, tracks the
// shift count, performs autopush, and raises a stall request when a blocking
// push meets a full RX FIFO.
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   penable, stalled       machine tick / machine stalled (active = penable & ~stalled)
//   shift_right            1: new bits enter at MSB, 0: new bits enter at LSB
//   auto_push, thresh      autopush enable and threshold (0 encodes 32)
//   do_in, in_bits, din    IN strobe, bit count (0 encodes 32), source data
//   do_push, if_full, block explicit PUSH and its qualifiers
//   do_mov                 MOV to ISR (loads din)
//   rx_full                RX FIFO full
//   rx_push, rx_data       registered one-cycle FIFO write strobe and data
//   dout, shift_count      current ISR value and shift count (0..32)
//   stall_req              combinational: operation cannot complete this cycle

module pio_isr #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             penable,
  input  logic             stalled,
  input  logic             shift_right,
  input  logic             auto_push,
  input  logic [4:0]       thresh,
  input  logic             do_in,
  input  logic [4:0]       in_bits,
  input  logic [WIDTH-1:0] din,
  input  logic             do_push,
  input  logic             if_full,
  input  logic             block,
  input  logic             do_mov,
  input  logic             rx_full,
  output logic             rx_push,
  output logic [WIDTH-1:0] rx_data,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] shift_count,
  output logic             stall_req
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

  logic [WIDTH-1:0] isr_q, isr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_d;
  logic [WIDTH-1:0] data_d;

  logic             active;
  logic [CNT_W-1:0] t_eff;
  logic [CNT_W-1:0] n_eff;
  logic [WIDTH-1:0] din_mask;
  logic [WIDTH-1:0] din_bits;
  logic [WIDTH-1:0] isr_shifted;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_in;
  logic             thresh_met;

  assign active = penable & ~stalled;

  // Zero-encoded fields mean the full register width.
  assign t_eff = (thresh == 5'd0) ? FULL_CNT : CNT_W'(thresh);
  assign n_eff = (in_bits == 5'd0) ? FULL_CNT : CNT_W'(in_bits);

  // A shift by the full width yields zero, so N=32 gives an all-ones mask
  // and a fully replaced ISR in both directions without special cases.
  assign din_mask = ~({WIDTH{1'b1}} << n_eff);
  assign din_bits = din & din_mask;

  always_comb begin
    isr_shifted = '0;
    if (shift_right) begin
      isr_shifted = (isr_q >> n_eff) | (din_bits << (FULL_CNT - n_eff));
    end else begin
      isr_shifted = (isr_q << n_eff) | din_bits;
    end
  end

  // Count saturates at the register width instead of wrapping.
  assign cnt_sum = {1'b0, cnt_q} + {1'b0, n_eff};
  assign cnt_in  = (cnt_sum > {1'b0, FULL_CNT}) ? FULL_CNT : cnt_sum[CNT_W-1:0];

  assign thresh_met = (cnt_in >= t_eff);

  always_comb begin
    isr_d     = isr_q;
    cnt_d     = cnt_q;
    push_d    = 1'b0;
    data_d    = rx_data;
    stall_req = 1'b0;

    if (active) begin
      if (do_mov) begin
        isr_d = din;
        cnt_d = '0;
      end else if (do_push) begin
        if (if_full && (cnt_q < t_eff)) begin
          // Below threshold: conditional push is a no-op.
          isr_d = isr_q;
        end else if (!rx_full) begin
          push_d = 1'b1;
          data_d = isr_q;
          isr_d  = '0;
          cnt_d  = '0;
        end else if (block) begin
          stall_req = 1'b1;
        end else begin
          // Non-blocking push into a full FIFO drops the data.
          isr_d = '0;
          cnt_d = '0;
        end
      end else if (do_in) begin
        if (auto_push && thresh_met) begin
          if (!rx_full) begin
            push_d = 1'b1;
            data_d = isr_shifted;
            isr_d  = '0;
            cnt_d  = '0;
          end else begin
            // Hold everything; the decoder re-issues the IN.
            stall_req = 1'b1;
          end
        end else begin
          isr_d = isr_shifted;
          cnt_d = cnt_in;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      isr_q   <= '0;
      cnt_q   <= '0;
      rx_push <= 1'b0;
      rx_data <= '0;
    end else begin
      isr_q   <= isr_d;
      cnt_q   <= cnt_d;
      rx_push <= push_d;
      rx_data <= data_d;
    end
  end

  assign dout        = isr_q;
  assign shift_count = cnt_q;

endmodule

// File: tb/tb_pio_isr.sv
// tb/tb_pio_isr.sv - scoreboard testbench for pio_isr
module tb_pio_isr;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        penable, stalled, shift_right, auto_push;
  logic [4:0]  thresh, in_bits;
  logic        do_in, do_push, if_full, block, do_mov, rx_full;
  logic [31:0] din;
  logic        rx_push;
  logic [31:0] rx_data, dout;
  logic [5:0]  shift_count;
  logic        stall_req;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pio_isr dut (
    .clk(clk), .reset_n(reset_n), .penable(penable), .stalled(stalled),
    .shift_right(shift_right), .auto_push(auto_push), .thresh(thresh),
    .do_in(do_in), .in_bits(in_bits), .din(din), .do_push(do_push),
    .if_full(if_full), .block(block), .do_mov(do_mov), .rx_full(rx_full),
    .rx_push(rx_push), .rx_data(rx_data), .dout(dout),
    .shift_count(shift_count), .stall_req(stall_req)
  );

  // Monitor: every observed FIFO write must match the oldest expected push.
  always @(negedge clk) begin
    if (rx_push) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rx_unexpected: rx_push=1 rx_data=%08h, required no push", rx_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          failures++;
          $display("FAIL rx_data: got %08h, required %08h", rx_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h, required %08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    do_in = 0; do_push = 0; do_mov = 0; if_full = 0; block = 0;
    penable = 1; stalled = 0;
  endtask

  task automatic op_in(input logic [4:0] n, input logic [31:0] d);
    clr(); do_in = 1; in_bits = n; din = d; cyc(); clr();
  endtask

  task automatic op_mov(input logic [31:0] d);
    clr(); do_mov = 1; din = d; cyc(); clr();
  endtask

  initial begin
    reset_n = 0; shift_right = 0; auto_push = 0; thresh = 0; in_bits = 0;
    din = 0; rx_full = 0; clr();
    cyc(); cyc();
    chk("reset_dout", dout, 0);
    chk("reset_cnt", 32'(shift_count), 0);
    chk("reset_rx_push", 32'(rx_push), 0);
    chk("reset_rx_data", rx_data, 0);
    reset_n = 1;

    // 1: left shift, no autopush
    op_in(8, 32'hAB); op_in(8, 32'hCD);
    chk("t1_dout", dout, 32'h0000ABCD);
    chk("t1_cnt", 32'(shift_count), 16);

    // 2: right shift and count saturation
    op_mov(0); shift_right = 1;
    op_in(4, 32'hF); op_in(4, 32'h1);
    chk("t2_dout", dout, 32'h1F000000);
    chk("t2_cnt", 32'(shift_count), 8);
    for (int i = 0; i < 6; i++) op_in(4, 0);
    chk("t2_cnt_32", 32'(shift_count), 32);
    op_in(4, 0);
    chk("t2_cnt_sat", 32'(shift_count), 32);

    // 3: autopush thresh=8
    op_mov(0); shift_right = 0; auto_push = 1; thresh = 8; rx_full = 0;
    clr(); do_in = 1; in_bits = 8; din = 32'h5A; #1;
    chk("t3_stall", 32'(stall_req), 0);
    exp_q.push_back(32'h0000005A);
    cyc(); clr();
    chk("t3_rx_push", 32'(rx_push), 1);
    chk("t3_dout", dout, 0);
    chk("t3_cnt", 32'(shift_count), 0);

    // 4: autopush into full FIFO stalls, then completes
    op_mov(32'h00000011);
    rx_full = 1; do_in = 1; in_bits = 8; din = 32'h5A; #1;
    chk("t4_stall", 32'(stall_req), 1);
    cyc();
    chk("t4_hold_dout", dout, 32'h00000011);
    chk("t4_hold_cnt", 32'(shift_count), 0);
    chk("t4_no_push", 32'(rx_push), 0);
    rx_full = 0; #1;
    chk("t4_unstall", 32'(stall_req), 0);
    exp_q.push_back(32'h0000115A);
    cyc(); clr();
    chk("t4_dout", dout, 0);

    // thresh=0 means 32
    thresh = 0;
    op_in(16, 32'hFFFF1234);
    chk("thr32_cnt", 32'(shift_count), 16);
    chk("thr32_nopush", 32'(rx_push), 0);
    exp_q.push_back(32'h12345678);
    op_in(16, 32'h00005678);
    chk("thr32_cnt0", 32'(shift_count), 0);
    auto_push = 0; thresh = 8;

    // 5: PUSH variants with ISR=0x12345678, count=32
    op_in(0, 32'h12345678);
    chk("t5_load", dout, 32'h12345678);
    chk("t5_cnt", 32'(shift_count), 32);
    rx_full = 1; do_push = 1; block = 0; cyc(); clr();
    chk("t5_drop_dout", dout, 0);
    chk("t5_drop_cnt", 32'(shift_count), 0);
    chk("t5_drop_nopush", 32'(rx_push), 0);
    op_in(0, 32'h12345678);
    do_push = 1; block = 1; #1;
    chk("t5_block_stall", 32'(stall_req), 1);
    cyc(); clr();
    chk("t5_block_dout", dout, 32'h12345678);
    chk("t5_block_cnt", 32'(shift_count), 32);
    rx_full = 0;
    op_mov(0); op_in(4, 32'h3);
    do_push = 1; if_full = 1; #1;
    chk("t5_iffull_stall", 32'(stall_req), 0);
    cyc(); clr();
    chk("t5_iffull_dout", dout, 32'h00000003);
    chk("t5_iffull_cnt", 32'(shift_count), 4);
    chk("t5_iffull_nopush", 32'(rx_push), 0);
    op_mov(32'hCAFEF00D);
    exp_q.push_back(32'hCAFEF00D);
    do_push = 1; cyc(); clr();
    chk("t5_push0_dout", dout, 0);

    // 6: priority, inactive cycles, reset mid-stall
    do_mov = 1; do_in = 1; do_push = 1; in_bits = 8; din = 32'hDEADBEEF; cyc(); clr();
    chk("t6_mov_dout", dout, 32'hDEADBEEF);
    chk("t6_mov_cnt", 32'(shift_count), 0);
    chk("t6_mov_nopush", 32'(rx_push), 0);
    stalled = 1; do_in = 1; din = 32'hFF; cyc();
    chk("t6_stalled_dout", dout, 32'hDEADBEEF);
    chk("t6_stalled_cnt", 32'(shift_count), 0);
    stalled = 0; penable = 0; rx_full = 1; do_in = 0; do_push = 1; block = 1; #1;
    chk("t6_inactive_stall", 32'(stall_req), 0);
    cyc(); clr();
    chk("t6_inactive_dout", dout, 32'hDEADBEEF);
    auto_push = 1; thresh = 8; do_in = 1; in_bits = 8; din = 32'h77; #1;
    chk("t6_pre_reset_stall", 32'(stall_req), 1);
    reset_n = 0; rx_full = 0; cyc(); clr();
    chk("t6_rst_dout", dout, 0);
    chk("t6_rst_cnt", 32'(shift_count), 0);
    chk("t6_rst_rx_push", 32'(rx_push), 0);
    chk("t6_rst_rx_data", rx_data, 0);
    reset_n = 1;
    cyc(); cyc();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
